// File: rtl/div_pkg.sv
// div_pkg: constants and types shared by the restoring divider and its step.
//   DIV_WIDTH        divisor/quotient/remainder width (dividend is 2*DIV_WIDTH)
//   DIV_ITERS        number of shift-subtract iterations per division
//   DIV_ERR_QUOTIENT quotient reported on divide-by-zero or overflow
//   div_state_t      controller states
package div_pkg;

    localparam int unsigned DIV_WIDTH        = 16;
    localparam int unsigned DIV_ITERS        = 16;
    localparam logic [15:0] DIV_ERR_QUOTIENT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ITERATE,
        ST_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational iteration of a restoring divider.
//   i_r  partial remainder R (WIDTH+1 bits)
//   i_q  dividend-low / quotient shift register Q
//   i_d  divisor D
//   o_r  R after shift and conditional subtract
//   o_q  Q after shift, new quotient bit in o_q[0]
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    // One bit wider than R so the compare never loses the shifted-out bit.
    logic [WIDTH+1:0] w_r_shift;
    logic [WIDTH+1:0] w_d_ext;

    always_comb begin
        w_r_shift = {i_r, i_q[WIDTH-1]};
        w_d_ext   = {2'b00, i_d};
        o_q       = {i_q[WIDTH-2:0], 1'b0};
        o_r       = (WIDTH+1)'(w_r_shift);
        if (w_r_shift >= w_d_ext) begin
            o_r    = (WIDTH+1)'(w_r_shift - w_d_ext);
            o_q[0] = 1'b1;
        end
    end

endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per cycle.
//   clock       rising-edge clock
//   rst         asynchronous active-high reset
//   start       launch request, honoured only when idle or done
//   dividend    2*WIDTH-bit dividend, captured in LOAD
//   divisor     WIDTH-bit divisor, captured in LOAD
//   quotient    result quotient (all ones on error)
//   remainder   result remainder
//   div_by_zero divisor was zero
//   overflow    quotient would not fit in WIDTH bits
//   busy        operation in progress
//   completed   results valid
module divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow,
    output logic               busy,
    output logic               completed
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_next),
        .o_q (w_q_next)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            completed   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_r         <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                    r_q         <= dividend[WIDTH-1:0];
                    r_d         <= divisor;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    completed   <= 1'b0;
                    r_state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (r_d == '0) begin
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= r_q;
                        busy        <= 1'b0;
                        completed   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_r[WIDTH-1:0] >= r_d) begin
                        // High half >= divisor means the quotient needs more than WIDTH bits.
                        overflow  <= 1'b1;
                        quotient  <= '1;
                        remainder <= '0;
                        busy      <= 1'b0;
                        completed <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_ITERATE;
                    end
                end
                ST_ITERATE: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        quotient  <= w_q_next;
                        remainder <= w_r_next[WIDTH-1:0];
                        busy      <= 1'b0;
                        completed <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        completed <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against an arithmetic
// reference model; a per-cycle compare covers every output.
module tb_divider;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } res_t;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor  = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;
    logic        completed;

    int n_cmp = 0;
    int n_err = 0;

    divider #(.WIDTH(16)) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy),
        .completed   (completed)
    );

    always #5 clock = ~clock;

    // Result of one division from plain integer arithmetic.
    function automatic res_t model_div(input logic [31:0] n, input logic [15:0] d);
        res_t        res;
        logic [31:0] qq;
        res = '0;
        if (d == 16'd0) begin
            res.dbz = 1'b1;
            res.q   = 16'hFFFF;
            res.r   = n[15:0];
        end else begin
            qq = n / {16'd0, d};
            if (qq > 32'd65535) begin
                res.ovf = 1'b1;
                res.q   = 16'hFFFF;
                res.r   = 16'd0;
            end else begin
                res.q = qq[15:0];
                res.r = 16'(n % {16'd0, d});
            end
        end
        return res;
    endfunction

    function automatic int model_latency(input res_t res);
        return (res.dbz || res.ovf) ? 2 : 18;
    endfunction

    // Reference timing: an accepted start yields results `latency` edges later;
    // operands are taken one edge after acceptance.
    logic        m_busy, m_completed, m_dbz, m_ovf;
    logic [15:0] m_q, m_r;
    res_t        m_pend;
    int          m_since;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_completed <= 1'b0;
            m_dbz       <= 1'b0;
            m_ovf       <= 1'b0;
            m_q         <= '0;
            m_r         <= '0;
            m_pend      <= '0;
            m_since     <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy      <= 1'b1;
                m_completed <= 1'b0;
                m_since     <= 0;
            end
        end else begin
            m_since <= m_since + 1;
            if (m_since == 0) begin
                m_pend <= model_div(dividend, divisor);
                m_dbz  <= 1'b0;
                m_ovf  <= 1'b0;
            end else if (m_since + 1 == model_latency(m_pend)) begin
                m_busy      <= 1'b0;
                m_completed <= 1'b1;
                m_q         <= m_pend.q;
                m_r         <= m_pend.r;
                m_dbz       <= m_pend.dbz;
                m_ovf       <= m_pend.ovf;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Launch one division and return the number of edges until completed.
    task automatic run_op(input logic [31:0] n, input logic [15:0] d,
                          input bit noisy, output int lat);
        @(negedge clock);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        while (!completed && lat < 40) begin
            // Requests during ITERATE must be ignored.
            if (noisy && lat >= 2 && lat <= 15)
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        if (!completed) check("completion_timeout", 32'(completed), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          per;
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] hi;
        int unsigned sel;
        res_t        exp_res;

        #1 rst = 1'b1;

        fork
            forever begin
                @(negedge clock);
                check("cmp_busy",        32'(busy),        32'(m_busy));
                check("cmp_completed",   32'(completed),   32'(m_completed));
                check("cmp_quotient",    32'(quotient),    32'(m_q));
                check("cmp_remainder",   32'(remainder),   32'(m_r));
                check("cmp_div_by_zero", 32'(div_by_zero), 32'(m_dbz));
                check("cmp_overflow",    32'(overflow),    32'(m_ovf));
            end
        join_none

        repeat (2) @(negedge clock);
        check("reset_quotient",  32'(quotient),  32'd0);
        check("reset_completed", 32'(completed), 32'd0);
        #2 rst = 1'b0;

        run_op(32'd100, 16'd7, 1'b0, lat);
        check("lat_100_7", 32'(lat), 32'd18);
        check("q_100_7", 32'(quotient), 32'd14);
        check("r_100_7", 32'(remainder), 32'd2);
        check("flags_100_7", {30'd0, div_by_zero, overflow}, 32'd0);

        run_op(32'hFFFE_0001, 16'hFFFF, 1'b0, lat);
        check("lat_max_q", 32'(lat), 32'd18);
        check("q_max_q", 32'(quotient), 32'hFFFF);
        check("r_max_q", 32'(remainder), 32'd0);
        check("ovf_max_q", 32'(overflow), 32'd0);

        run_op(32'd1234, 16'd0, 1'b0, lat);
        check("lat_dbz", 32'(lat), 32'd2);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check("q_dbz", 32'(quotient), 32'hFFFF);
        check("r_dbz", 32'(remainder), 32'd1234);

        run_op(32'h0010_0000, 16'h0010, 1'b0, lat);
        check("lat_ovf", 32'(lat), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("q_ovf", 32'(quotient), 32'hFFFF);
        check("r_ovf", 32'(remainder), 32'd0);

        // Reset in the middle of iteration 8, then a fresh run of the same operands.
        run_op(32'd100, 16'd7, 1'b0, lat);
        @(negedge clock);
        dividend = 32'd50000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 rst = 1'b1;
        @(negedge clock);
        check("rst_mid_quotient",  32'(quotient),  32'd0);
        check("rst_mid_remainder", 32'(remainder), 32'd0);
        check("rst_mid_busy",      32'(busy),      32'd0);
        check("rst_mid_completed", 32'(completed), 32'd0);
        #2 rst = 1'b0;
        run_op(32'd50000, 16'd3, 1'b0, lat);
        check("lat_50000_3", 32'(lat), 32'd18);
        check("q_50000_3", 32'(quotient), 32'd16666);
        check("r_50000_3", 32'(remainder), 32'd2);

        // Start held through DONE: back-to-back operations.
        @(negedge clock);
        dividend = 32'd9;
        divisor  = 16'd4;
        start    = 1'b1;
        @(negedge clock);
        lat = 0;
        while (!completed && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("b2b_lat1", 32'(lat), 32'd18);
        check("b2b_q1", 32'(quotient), 32'd2);
        check("b2b_r1", 32'(remainder), 32'd1);
        divisor = 16'd2;
        @(negedge clock);
        per = 1;
        check("b2b_completed_drop", 32'(completed), 32'd0);
        while (!completed && per < 40) begin
            @(negedge clock);
            per++;
        end
        start = 1'b0;
        check("b2b_period", 32'(per), 32'd19);
        check("b2b_q2", 32'(quotient), 32'd4);
        check("b2b_r2", 32'(remainder), 32'd1);

        // Randomized operations with idle gaps and ignored mid-run requests.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            sel = $urandom_range(0, 15);
            d   = 16'($urandom);
            if (sel == 0) d = 16'd0;
            else if (sel == 2) d = 16'($urandom_range(1, 15));
            if (sel == 1 || d == 16'd0) hi = 16'($urandom);
            else hi = 16'($urandom_range(0, 32'(d) - 1));
            n = {hi, 16'($urandom)};
            exp_res = model_div(n, d);
            run_op(n, d, 1'b1, lat);
            check("rand_latency", 32'(lat), 32'(model_latency(exp_res)));
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
